tour_sequencer: RTL and testbench

Controller between the command path and the knight's-tour solver. It accepts a tour-start command from the UART command stream and launches the solver. After the solver finishes, it walks the 24 stored moves and issues each one to the motion controller as two straight-line commands: a vertical leg, then a horizontal leg. When no tour is running it passes UART commands straight through, so it sits as the single command source for the motion controller.

---
 rtl/tour_pkg.sv | 29 ++
 rtl/tour_move_decode.sv | 39 +++
 rtl/tour_sequencer.sv | 174 +++++++++++++++++
 tb/tb_tour_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// Shared opcodes, headings and sequencer state encoding for the knight's-tour
// command path.
package tour_pkg;

    localparam logic [3:0] OP_MOVE     = 4'b0010;
    localparam logic [3:0] OP_MOVE_FAN = 4'b0011;
    localparam logic [3:0] OP_TOUR     = 4'b0100;

    localparam logic [7:0] HEAD_N = 8'h00;
    localparam logic [7:0] HEAD_W = 8'h3F;
    localparam logic [7:0] HEAD_S = 8'h7F;
    localparam logic [7:0] HEAD_E = 8'hBF;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GO         = 3'd1,
        ST_WAIT_SOLVE = 3'd2,
        ST_LOAD       = 3'd3,
        ST_VERT       = 3'd4,
        ST_WAIT_V     = 3'd5,
        ST_HORZ       = 3'd6,
        ST_WAIT_H     = 3'd7
    } tour_state_e;

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Turns one solver move (one-hot over the eight knight jumps) into the
// heading and square count of its vertical and horizontal legs.
module tour_move_decode
    import tour_pkg::*;
(
    input  logic [7:0] move,
    output logic [7:0] vert_head,
    output logic [3:0] vert_sq,
    output logic [7:0] horz_head,
    output logic [3:0] horz_sq,
    output logic       legal
);

    // Jump table: vertical leg first, horizontal leg second.
    always_comb begin
        vert_head = HEAD_N;
        vert_sq   = 4'd0;
        horz_head = HEAD_W;
        horz_sq   = 4'd0;
        legal     = is_onehot8(move);
        case (move)
            8'h01: begin vert_head = HEAD_N; vert_sq = 4'd2; horz_head = HEAD_W; horz_sq = 4'd1; end
            8'h02: begin vert_head = HEAD_N; vert_sq = 4'd2; horz_head = HEAD_E; horz_sq = 4'd1; end
            8'h04: begin vert_head = HEAD_N; vert_sq = 4'd1; horz_head = HEAD_W; horz_sq = 4'd2; end
            8'h08: begin vert_head = HEAD_S; vert_sq = 4'd1; horz_head = HEAD_W; horz_sq = 4'd2; end
            8'h10: begin vert_head = HEAD_S; vert_sq = 4'd2; horz_head = HEAD_W; horz_sq = 4'd1; end
            8'h20: begin vert_head = HEAD_S; vert_sq = 4'd2; horz_head = HEAD_E; horz_sq = 4'd1; end
            8'h40: begin vert_head = HEAD_S; vert_sq = 4'd1; horz_head = HEAD_E; horz_sq = 4'd2; end
            8'h80: begin vert_head = HEAD_N; vert_sq = 4'd1; horz_head = HEAD_E; horz_sq = 4'd2; end
            default: begin
                vert_head = HEAD_N;
                vert_sq   = 4'd0;
                horz_head = HEAD_W;
                horz_sq   = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/tour_sequencer.sv
// Launches the knight's-tour solver, then replays each stored move as a
// vertical and a horizontal leg; passes UART commands through when idle.
module tour_sequencer
    import tour_pkg::*;
#(
    parameter int NUM_MOVES    = 24,
    parameter bit FANFARE_LAST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic        tl_go,
    output logic [2:0]  tl_x_start,
    output logic [2:0]  tl_y_start,
    input  logic        tl_done,
    output logic [4:0]  tl_indx,
    input  logic [7:0]  tl_move,
    output logic        tour_busy,
    output logic        tour_err
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);
    localparam logic [3:0] HORZ_OP  = FANFARE_LAST ? OP_MOVE_FAN : OP_MOVE;

    tour_state_e state_r, state_s;
    logic [4:0]  cnt_r;
    logic [2:0]  x_r, y_r;
    logic [15:0] vert_cmd_r, horz_cmd_r, cmd_r;
    logic        cmd_rdy_r, tl_go_r, tour_err_r, tour_busy_r;
    logic        tour_req_s, last_s, legal_s;
    logic [7:0]  vert_head_s, horz_head_s;
    logic [3:0]  vert_sq_s, horz_sq_s;

    tour_move_decode u_decode (
        .move      (tl_move),
        .vert_head (vert_head_s),
        .vert_sq   (vert_sq_s),
        .horz_head (horz_head_s),
        .horz_sq   (horz_sq_s),
        .legal     (legal_s)
    );

    assign tour_req_s = cmd_rdy_UART && (cmd_UART[15:12] == OP_TOUR);
    assign last_s     = (cnt_r == LAST_IDX);

    // Next-state logic; handshakes only advance on an offered command.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tour_req_s) state_s = ST_GO;
                else            state_s = ST_IDLE;
            end
            ST_GO:         state_s = ST_WAIT_SOLVE;
            ST_WAIT_SOLVE: begin
                if (tl_done) state_s = ST_LOAD;
                else         state_s = ST_WAIT_SOLVE;
            end
            ST_LOAD: begin
                if (legal_s) state_s = ST_VERT;
                else         state_s = ST_IDLE;
            end
            ST_VERT: begin
                if (cmd_rdy_r && clr_cmd_rdy) state_s = ST_WAIT_V;
                else                          state_s = ST_VERT;
            end
            ST_WAIT_V: begin
                if (send_resp) state_s = ST_HORZ;
                else           state_s = ST_WAIT_V;
            end
            ST_HORZ: begin
                if (cmd_rdy_r && clr_cmd_rdy) state_s = ST_WAIT_H;
                else                          state_s = ST_HORZ;
            end
            ST_WAIT_H: begin
                if (send_resp && last_s)  state_s = ST_IDLE;
                else if (send_resp)       state_s = ST_LOAD;
                else                      state_s = ST_WAIT_H;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Move counter and start square, both captured on tour accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 5'd0;
            x_r   <= 3'd0;
            y_r   <= 3'd0;
        end else if (state_r == ST_IDLE && tour_req_s) begin
            cnt_r <= 5'd0;
            x_r   <= cmd_UART[6:4];
            y_r   <= cmd_UART[2:0];
        end else if (state_r == ST_WAIT_H && send_resp && !last_s) begin
            cnt_r <= cnt_r + 5'd1;
        end
    end

    // Leg commands are built once in LOAD and replayed from registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vert_cmd_r <= 16'h0000;
            horz_cmd_r <= 16'h0000;
        end else if (state_r == ST_LOAD) begin
            vert_cmd_r <= {OP_MOVE, vert_head_s, vert_sq_s};
            horz_cmd_r <= {HORZ_OP, horz_head_s, horz_sq_s};
        end
    end

    // Offer a leg the cycle after entering VERT/HORZ; drop it after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r     <= 16'h0000;
            cmd_rdy_r <= 1'b0;
        end else if (state_r == ST_VERT && !cmd_rdy_r) begin
            cmd_r     <= vert_cmd_r;
            cmd_rdy_r <= 1'b1;
        end else if (state_r == ST_HORZ && !cmd_rdy_r) begin
            cmd_r     <= horz_cmd_r;
            cmd_rdy_r <= 1'b1;
        end else if (cmd_rdy_r && clr_cmd_rdy) begin
            cmd_rdy_r <= 1'b0;
        end
    end

    // Status pulses and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tl_go_r     <= 1'b0;
            tour_err_r  <= 1'b0;
            tour_busy_r <= 1'b0;
        end else begin
            tl_go_r     <= (state_r == ST_IDLE) && tour_req_s;
            tour_err_r  <= (state_r == ST_LOAD) && !legal_s;
            tour_busy_r <= (state_s != ST_IDLE);
        end
    end

    // Idle passthrough; a TOUR request is swallowed rather than forwarded.
    always_comb begin
        cmd              = cmd_r;
        cmd_rdy          = cmd_rdy_r;
        clr_cmd_rdy_UART = 1'b0;
        if (state_r == ST_IDLE) begin
            cmd              = cmd_UART;
            cmd_rdy          = cmd_rdy_UART && !tour_req_s;
            clr_cmd_rdy_UART = tour_req_s || clr_cmd_rdy;
        end else begin
            cmd              = cmd_r;
            cmd_rdy          = cmd_rdy_r;
            clr_cmd_rdy_UART = 1'b0;
        end
    end

    assign tl_go      = tl_go_r;
    assign tl_x_start = x_r;
    assign tl_y_start = y_r;
    assign tl_indx    = cnt_r;
    assign tour_busy  = tour_busy_r;
    assign tour_err   = tour_err_r;

endmodule

// File: tb/tb_tour_sequencer.sv
// Bench for tour_sequencer: acts as UART, solver and motion controller, and
// predicts leg commands from knight-jump geometry.
module tb_tour_sequencer;

    localparam int NUM_MOVES = 24;
    localparam bit FAN       = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic        tl_go;
    logic [2:0]  tl_x_start, tl_y_start;
    logic        tl_done;
    logic [4:0]  tl_indx;
    logic [7:0]  tl_move;
    logic        tour_busy;
    logic        tour_err;

    logic [7:0] moves [32];
    int dx_tab [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
    int dy_tab [8] = '{ 2, 2, 1, -1, -2, -2, -1, 1};

    int errors = 0;
    int checks = 0;
    int accepted = 0;
    int go_cnt = 0;
    int err_cnt = 0;
    logic leak;

    assign tl_move = moves[tl_indx];

    always #10 clk = ~clk;

    tour_sequencer #(.NUM_MOVES(NUM_MOVES), .FANFARE_LAST(FAN)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
        .tl_go(tl_go), .tl_x_start(tl_x_start), .tl_y_start(tl_y_start),
        .tl_done(tl_done), .tl_indx(tl_indx), .tl_move(tl_move),
        .tour_busy(tour_busy), .tour_err(tour_err)
    );

    // Event counters observed at the active edge.
    always @(posedge clk) begin
        if (tour_busy && cmd_rdy && clr_cmd_rdy) accepted <= accepted + 1;
        if (tl_go) go_cnt <= go_cnt + 1;
        if (tour_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference: leg command from the jump's displacement on the board.
    function automatic logic [15:0] model_cmd(input logic [7:0] mv, input bit horiz);
        int b, d, sq;
        logic [3:0] op;
        logic [7:0] head;
        b = 0;
        for (int i = 0; i < 8; i++) if (mv[i]) b = i;
        d  = horiz ? dx_tab[b] : dy_tab[b];
        sq = (d < 0) ? -d : d;
        op = (horiz && FAN) ? 4'b0011 : 4'b0010;
        if (horiz) head = (d < 0) ? 8'h3F : 8'hBF;
        else       head = (d > 0) ? 8'h00 : 8'h7F;
        return {op, head, 4'(sq)};
    endfunction

    task automatic fill_moves();
        for (int i = 0; i < 32; i++) moves[i] = 8'h01 << $urandom_range(0, 7);
    endtask

    task automatic start_tour(input logic [2:0] x, input logic [2:0] y, input bit prio);
        cmd_UART     = {4'b0100, 5'b00000, x, 1'b0, y};
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy  = prio;
        #1;
        check("accept_clr_uart", 32'(clr_cmd_rdy_UART), 32'd1);
        check("accept_no_passthru", 32'(cmd_rdy), 32'd0);
        tick();
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy  = 1'b0;
        check("tl_go_high", 32'(tl_go), 32'd1);
        check("tl_x_start", 32'(tl_x_start), 32'(x));
        check("tl_y_start", 32'(tl_y_start), 32'(y));
        check("busy_start", 32'(tour_busy), 32'd1);
        tick();
        check("tl_go_low", 32'(tl_go), 32'd0);
        repeat ($urandom_range(0, 3)) tick();
        tl_done = 1'b1;
        tick();
        tl_done = 1'b0;
    endtask

    task automatic serve_cmd(input logic [15:0] exp, input int idx, input bit dual, input bit no_resp);
        int waited;
        waited = 0;
        while (cmd_rdy !== 1'b1 && waited < 60) begin
            leak = leak | clr_cmd_rdy_UART;
            tick();
            waited++;
        end
        check("cmd_rdy_wait", 32'(cmd_rdy), 32'd1);
        if (cmd_rdy === 1'b1) begin
            check("cmd", 32'(cmd), 32'(exp));
            check("tl_indx", 32'(tl_indx), 32'(idx));
            repeat ($urandom_range(0, 2)) tick();
            check("cmd_stable", 32'(cmd), 32'(exp));
            clr_cmd_rdy = 1'b1;
            send_resp   = dual;
            tick();
            clr_cmd_rdy = 1'b0;
            send_resp   = 1'b0;
            check("cmd_rdy_fall", 32'(cmd_rdy), 32'd0);
            if (!no_resp) begin
                repeat ($urandom_range(0, 2)) tick();
                send_resp = 1'b1;
                tick();
                send_resp = 1'b0;
            end
        end
    endtask

    task automatic run_tour(input logic [2:0] x, input logic [2:0] y, input int bad_idx, input bit prio);
        int base_acc, base_err, n_ok, waited;
        logic saw_rdy;
        start_tour(x, y, prio);
        base_acc     = accepted;
        base_err     = err_cnt;
        cmd_UART     = 16'h2005;
        cmd_rdy_UART = (bad_idx < 0);
        leak         = 1'b0;
        n_ok         = (bad_idx < 0) ? NUM_MOVES : bad_idx;
        for (int m = 0; m < n_ok; m++) begin
            serve_cmd(model_cmd(moves[m], 1'b0), m, 1'($urandom_range(0, 1)), 1'b0);
            serve_cmd(model_cmd(moves[m], 1'b1), m, 1'($urandom_range(0, 1)), 1'b0);
        end
        if (bad_idx < 0) begin
            check("busy_end", 32'(tour_busy), 32'd0);
            check("indx_end", 32'(tl_indx), 32'(NUM_MOVES - 1));
            check("cmd_count", 32'(accepted - base_acc), 32'(2 * NUM_MOVES));
            check("uart_ignored", 32'(leak), 32'd0);
            check("passthru_after", 32'(cmd), 32'h2005);
            check("passthru_rdy_after", 32'(cmd_rdy), 32'd1);
            cmd_rdy_UART = 1'b0;
        end else begin
            saw_rdy = 1'b0;
            waited  = 0;
            while (tour_err !== 1'b1 && waited < 20) begin
                saw_rdy = saw_rdy | cmd_rdy;
                tick();
                waited++;
            end
            check("tour_err_pulse", 32'(tour_err), 32'd1);
            check("err_busy", 32'(tour_busy), 32'd0);
            check("err_no_cmd", 32'(saw_rdy), 32'd0);
            check("err_indx", 32'(tl_indx), 32'(bad_idx));
            tick();
            check("tour_err_one_cycle", 32'(tour_err), 32'd0);
            check("err_count", 32'(err_cnt - base_err), 32'd1);
            check("err_cmd_count", 32'(accepted - base_acc), 32'(2 * bad_idx));
        end
    endtask

    initial begin
        int go_before;
        logic [15:0] v;
        logic r, c;
        rst_n        = 1'b0;
        cmd_UART     = 16'h0000;
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        tl_done      = 1'b0;
        leak         = 1'b0;
        fill_moves();
        repeat (3) tick();
        check("rst_cmd", 32'(cmd), 32'h0000);
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("rst_tl_go", 32'(tl_go), 32'd0);
        check("rst_tl_indx", 32'(tl_indx), 32'd0);
        check("rst_tl_x", 32'(tl_x_start), 32'd0);
        check("rst_tl_y", 32'(tl_y_start), 32'd0);
        check("rst_busy", 32'(tour_busy), 32'd0);
        check("rst_err", 32'(tour_err), 32'd0);
        check("rst_clr_uart", 32'(clr_cmd_rdy_UART), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed passthrough.
        cmd_UART = 16'h2003;
        cmd_rdy_UART = 1'b1;
        #1;
        check("pt_cmd", 32'(cmd), 32'h2003);
        check("pt_rdy", 32'(cmd_rdy), 32'd1);
        clr_cmd_rdy = 1'b1;
        #1;
        check("pt_clr_echo", 32'(clr_cmd_rdy_UART), 32'd1);
        tick();
        clr_cmd_rdy = 1'b0;
        cmd_rdy_UART = 1'b0;

        // Random non-TOUR passthrough.
        for (int i = 0; i < 4; i++) begin
            v = 16'($urandom);
            if (v[15:12] == 4'b0100) v[12] = 1'b1;
            r = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            cmd_UART = v; cmd_rdy_UART = r; clr_cmd_rdy = c;
            #1;
            check("rpt_cmd", 32'(cmd), 32'(v));
            check("rpt_rdy", 32'(cmd_rdy), 32'(r));
            check("rpt_clr", 32'(clr_cmd_rdy_UART), 32'(c));
            tick();
        end
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy  = 1'b0;
        tick();

        // Full tour, first move N2/W1, TOUR colliding with a passthrough accept.
        moves[0] = 8'h01;
        run_tour(3'd2, 3'd2, -1, 1'b1);
        tick();

        // Full tour with random moves and start square.
        fill_moves();
        run_tour(3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), -1, 1'b0);
        tick();

        // Illegal move at index 5.
        fill_moves();
        moves[5] = 8'h03;
        run_tour(3'd0, 3'd3, 5, 1'b0);
        tick();

        // Reset while waiting for the vertical-leg response.
        fill_moves();
        start_tour(3'd1, 3'd4, 1'b0);
        serve_cmd(model_cmd(moves[0], 1'b0), 0, 1'b0, 1'b1);
        go_before = go_cnt;
        #3 rst_n = 1'b0;
        #1;
        check("mr_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("mr_busy", 32'(tour_busy), 32'd0);
        check("mr_tl_x", 32'(tl_x_start), 32'd0);
        check("mr_tl_y", 32'(tl_y_start), 32'd0);
        cmd_UART = 16'h2007;
        cmd_rdy_UART = 1'b1;
        #1;
        check("mr_passthru_in_rst", 32'(cmd), 32'h2007);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("mr_passthru_cmd", 32'(cmd), 32'h2007);
        check("mr_passthru_rdy", 32'(cmd_rdy), 32'd1);
        check("mr_no_relaunch", 32'(go_cnt), 32'(go_before));
        cmd_rdy_UART = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
